lsu_mem_interface: RTL and testbench

//  Load/store unit: consumes memRD/memWR/memCtrl from the decode controller, plus ALU address and rs2 data.

---
 rtl/lsu_mem_interface.sv | 177 +++++++++++++++++
 tb/tb_lsu_mem_interface.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_interface.sv
// MEM-stage load/store unit: decodes memRD/memWR/memCtrl, drives a req/gnt/rvalid bus and extends loads.
// Store done 2 cycles after start, load 3 (zero-wait bus); stall holds the pipeline while REQ/WAIT is pending.
module lsu_mem_interface #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRD,
    input  logic        memWR,
    input  logic [2:0]  memCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misalign,
    output logic        lsu_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        mis_q;
    logic [1:0]  lane_q;
    logic [2:0]  ctrl_q;

    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        bad_combo;
    logic        misaligned;
    logic        start_ok;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] rdata_d;
    logic        timeout;

    always_comb begin
        is_store   = (memCtrl == 3'b101) || (memCtrl == 3'b110) || (memCtrl == 3'b111);
        is_half    = (memCtrl == 3'b001) || (memCtrl == 3'b100) || (memCtrl == 3'b110);
        is_word    = (memCtrl == 3'b010) || (memCtrl == 3'b111);
        bad_combo  = (memRD & memWR) | (memRD & is_store) | (memWR & ~is_store);
        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        start_ok   = (memRD ^ memWR) & ~bad_combo & ~misaligned;

        be_d    = 4'b1111;
        wdata_d = 32'h0;
        case (memCtrl)
            3'b101: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            3'b110: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            3'b111:  wdata_d = wdata;
            default: wdata_d = 32'h0;
        endcase
    end

    // Load extraction uses the latched control, since inputs may change after start.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ctrl_q)
            3'b000:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  rdata_d = {{16{ld_half[15]}}, ld_half};
            3'b011:  rdata_d = {24'h0, ld_byte};
            3'b100:  rdata_d = {16'h0, ld_half};
            default: rdata_d = dmem_rdata;
        endcase
        timeout = (cnt_q == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            lane_q  <= 2'b00;
            ctrl_q  <= 3'b000;
        end else begin
            err_q <= 1'b0;
            mis_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (memRD | memWR) begin
                        if (bad_combo) begin
                            err_q <= 1'b1;
                        end else if (misaligned) begin
                            mis_q <= 1'b1;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= memWR;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            lane_q  <= addr[1:0];
                            ctrl_q  <= memCtrl;
                            cnt_q   <= 8'h0;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        if (!we_q) rdata_q <= 32'h0;
                        state_q <= S_DONE;
                    end else if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                        state_q <= S_DONE;
                    end else if (dmem_rvalid) begin
                        rdata_q <= rdata_d;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall    = ((state_q == S_IDLE) & start_ok) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign lsu_done     = (state_q == S_DONE);
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = mis_q;
    assign lsu_err      = err_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Scoreboard bench for lsu_mem_interface with TIMEOUT=4 and a programmable grant/rvalid responder.
module tb_lsu_mem_interface;

    logic        clk;
    logic        rst_n;
    logic        memRD, memWR;
    logic [2:0]  memCtrl;
    logic [31:0] addr, wdata;
    logic        lsu_stall, lsu_done, lsu_misalign, lsu_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    lsu_mem_interface #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .memRD(memRD), .memWR(memWR), .memCtrl(memCtrl),
        .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .lsu_misalign(lsu_misalign), .lsu_err(lsu_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        int          cyc;
        logic        done;
        logic        err;
        logic        mis;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    bus_t  cur_bus;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          gnt_wait = 0;
    int          rv_wait = 0;
    logic [31:0] rd_word = 32'h0;
    int          req_cnt = 0;
    int          rv_cnt = 0;
    logic        rv_pending = 1'b0;
    logic        req_prev = 1'b0;
    int          req_len = 0;
    logic [31:0] model_rdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: grant after gnt_wait request cycles, rvalid rv_wait cycles after the grant cycle.
    always begin
        @(posedge clk);
        #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!rst_n) begin
            req_cnt    = 0;
            rv_pending = 1'b0;
        end else if (rv_pending) begin
            if (rv_cnt == rv_wait) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rd_word;
                rv_pending  = 1'b0;
            end else begin
                rv_cnt++;
            end
        end else if (dmem_req) begin
            if (req_cnt == gnt_wait) begin
                dmem_gnt = 1'b1;
                req_cnt  = 0;
                if (!dmem_we) begin
                    rv_pending = 1'b1;
                    rv_cnt     = 0;
                end
            end else begin
                req_cnt++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a bus request or a completion pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: dmem_req high with no expected access (cycle %0d)", cyc);
                    cur_bus.len = 0;
                end else begin
                    cur_bus = bus_q.pop_front();
                    check("req_cycle", cyc, cur_bus.cyc);
                    check("req_we", dmem_we, cur_bus.we);
                    check("req_addr", dmem_addr, cur_bus.addr);
                    check("req_be", dmem_be, cur_bus.be);
                    if (cur_bus.we) check("req_wdata", dmem_wdata, cur_bus.wdata);
                end
                req_len = 1;
            end else if (dmem_req) begin
                req_len++;
            end else if (req_prev) begin
                check("req_len", req_len, cur_bus.len);
            end
            if (lsu_done || lsu_err || lsu_misalign) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: done=%b err=%b mis=%b with none expected (cycle %0d)",
                             lsu_done, lsu_err, lsu_misalign, cyc);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_done", lsu_done, e.done);
                    check("resp_err", lsu_err, e.err);
                    check("resp_mis", lsu_misalign, e.mis);
                    check("resp_rdata", lsu_rdata, e.rdata);
                end
            end
            req_prev = dmem_req;
        end else begin
            req_prev = 1'b0;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gw, input int rw, input logic [31:0] rword,
                         input logic exp_stall, input logic has_bus, input logic [3:0] ebe,
                         input logic [31:0] ewd, input int elen, input int lat,
                         input logic edone, input logic eerr, input logic emis,
                         input logic [31:0] erd);
        bus_t  b;
        resp_t r;
        int    t0;
        @(posedge clk);
        #1;
        gnt_wait = gw;
        rv_wait  = rw;
        rd_word  = rword;
        req_cnt  = 0;
        memRD    = rd;
        memWR    = wr;
        memCtrl  = ctrl;
        addr     = a;
        wdata    = wd;
        t0       = cyc;
        if (has_bus) begin
            b.cyc = t0 + 1; b.we = wr; b.addr = {a[31:2], 2'b00};
            b.be = ebe; b.wdata = ewd; b.len = elen;
            bus_q.push_back(b);
        end
        r.cyc = t0 + lat; r.done = edone; r.err = eerr; r.mis = emis; r.rdata = erd;
        resp_q.push_back(r);
        #1;
        check("stall_at_start", lsu_stall, exp_stall);
        @(posedge clk);
        #1;
        memRD = 1'b0;
        memWR = 1'b0;
    endtask

    task automatic ld(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] rword,
                      input logic [31:0] erd);
        model_rdata = erd;
        issue(1'b1, 1'b0, ctrl, a, 32'h0, 0, 0, rword, 1'b1, 1'b1, 4'hF, 32'h0, 1, 3,
              1'b1, 1'b0, 1'b0, erd);
        repeat (6) @(posedge clk);
    endtask

    task automatic st(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ebe, input logic [31:0] ewd);
        issue(1'b0, 1'b1, ctrl, a, wd, 0, 0, 32'h0, 1'b1, 1'b1, ebe, ewd, 1, 2,
              1'b1, 1'b0, 1'b0, model_rdata);
        repeat (6) @(posedge clk);
    endtask

    task automatic rej(input logic rd, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic eerr, input logic emis);
        issue(rd, wr, ctrl, a, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1,
              1'b0, eerr, emis, model_rdata);
        repeat (6) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; memRD = 1'b0; memWR = 1'b0; memCtrl = 3'b000;
        addr = 32'h0; wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {lsu_stall, lsu_done, lsu_misalign, lsu_err, dmem_req, dmem_we, dmem_be}, 32'h0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // LW with stall profile T..T+2 and done at T+3.
        model_rdata = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b1, 1'b1, 4'hF, 32'h0, 1, 3,
              1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        check("lw_stall_t1", lsu_stall, 1'b1);
        @(posedge clk); #1;
        check("lw_stall_t2", lsu_stall, 1'b1);
        @(posedge clk); #1;
        check("lw_stall_t3", lsu_stall, 1'b0);
        repeat (4) @(posedge clk);

        ld(3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80);
        ld(3'b011, 32'h103, 32'h80123456, 32'h00000080);
        ld(3'b100, 32'h102, 32'h8ABC1234, 32'h00008ABC);
        ld(3'b001, 32'h102, 32'h8ABC1234, 32'hFFFF8ABC);
        ld(3'b001, 32'h100, 32'h8ABC1234, 32'h00001234);
        ld(3'b000, 32'h101, 32'h0000F500, 32'hFFFFFFF5);

        // Load timeout in WAIT; rvalid arrives in the timeout cycle and must be ignored.
        model_rdata = 32'h0;
        issue(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 0, 2, 32'h55555555, 1'b1, 1'b1, 4'hF, 32'h0, 1, 5,
              1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) @(posedge clk);

        ld(3'b010, 32'h104, 32'h11112222, 32'h11112222);
        st(3'b110, 32'h206, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
        st(3'b110, 32'h204, 32'h1234ABCD, 4'b0011, 32'hABCDABCD);
        st(3'b101, 32'h301, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
        st(3'b111, 32'h40C, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        rej(1'b1, 1'b0, 3'b010, 32'h101, 1'b0, 1'b1);
        rej(1'b0, 1'b1, 3'b110, 32'h201, 1'b0, 1'b1);
        rej(1'b1, 1'b1, 3'b010, 32'h100, 1'b1, 1'b0);
        rej(1'b1, 1'b0, 3'b111, 32'h100, 1'b1, 1'b0);
        rej(1'b0, 1'b1, 3'b010, 32'h100, 1'b1, 1'b0);

        // Grant never comes: four request cycles, then done+err; load data forced to zero.
        model_rdata = 32'h0;
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, -1, 0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 4, 5,
              1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) @(posedge clk);

        ld(3'b010, 32'h504, 32'h77778888, 32'h77778888);
        // Store timeout with grant in the timeout cycle; load data stays held.
        issue(1'b0, 1'b1, 3'b111, 32'h600, 32'h01020304, 3, 0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h01020304, 4, 5,
              1'b1, 1'b1, 1'b0, 32'h77778888);
        repeat (6) @(posedge clk);

        // Async reset while in WAIT abandons the access.
        issue(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 0, 5, 32'h99999999, 1'b1, 1'b1, 4'hF, 32'h0, 1, 3,
              1'b0, 1'b0, 1'b0, 32'h0);
        void'(resp_q.pop_back());
        @(posedge clk); #1;
        check("wait_stall", lsu_stall, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", dmem_req, 1'b0);
        check("rst_stall_drop", lsu_stall, 1'b0);
        check("rst_rdata_clear", lsu_rdata, 32'h0);
        model_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        st(3'b111, 32'h800, 32'h0BADF00D, 4'hF, 32'h0BADF00D);

        repeat (4) @(posedge clk);
        check("resp_q_drained", resp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
